serv_bufreg2_w: RTL and testbench



---
 rtl/serv_bufreg2_w_if.sv | 35 +++
 rtl/serv_bufreg2_w.sv | 112 +++++++++++
 tb/tb_serv_bufreg2_w.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_bufreg2_w_if.sv
// Bus bundle for serv_bufreg2_w: decoder operands, memory data and shifter control.
// The master side drives the i_* signals, the slave (the buffer register) drives o_*.
interface serv_bufreg2_w_if #(
    parameter int W = 1
);
    logic         i_en;
    logic         i_init;
    logic         i_cnt_done;
    logic         i_shift_op;
    logic         i_byte_valid;
    logic         i_load;
    logic [31:0]  i_dat;
    logic         i_op_b_sel;
    logic [W-1:0] i_rs2;
    logic [W-1:0] i_imm;
    logic [1:0]   i_lsb;
    logic [W-1:0] o_op_b;
    logic [31:0]  o_dat;
    logic [W-1:0] o_q;
    logic         o_sh_done;
    logic         o_sh_done_r;
    logic         o_busy;

    modport master (
        output i_en, i_init, i_cnt_done, i_shift_op, i_byte_valid, i_load,
               i_dat, i_op_b_sel, i_rs2, i_imm, i_lsb,
        input  o_op_b, o_dat, o_q, o_sh_done, o_sh_done_r, o_busy
    );

    modport slave (
        input  i_en, i_init, i_cnt_done, i_shift_op, i_byte_valid, i_load,
               i_dat, i_op_b_sel, i_rs2, i_imm, i_lsb,
        output o_op_b, o_dat, o_q, o_sh_done, o_sh_done_r, o_busy
    );
endinterface

// File: rtl/serv_bufreg2_w.sv
// Second buffer register for W-bit-per-cycle SERV cores: store/load data plus a
// dedicated shift-amount counter, so the data word is never disturbed while counting.
module serv_bufreg2_w #(
    parameter int W    = 1,
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    serv_bufreg2_w_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, SHIFT, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] dat;
    logic [XLEN-1:0] dat_next;
    logic [5:0]      shamt;
    logic            sh_done;
    logic            sh_done_r;
    logic            busy;
    logic            fill;
    logic [W-1:0]    op_b;
    logic [W-1:0]    q;

    assign op_b = bus.i_op_b_sel ? bus.i_rs2 : bus.i_imm;

    // Fill only happens before the shift count starts; a bus load always wins.
    assign fill = bus.i_en & ((state == IDLE) | (state == INIT)) &
                  (bus.i_byte_valid | (bus.i_shift_op & (state == INIT)));

    always_comb begin
        dat_next = dat;
        if (bus.i_load) begin
            dat_next = bus.i_dat;
        end else if (fill) begin
            dat_next = {op_b, dat[XLEN-1:W]};
        end
    end

    always_comb begin
        q = dat[W-1:0];
        case (bus.i_lsb)
            2'd1:    q = dat[8 +: W];
            2'd2:    q = dat[16 +: W];
            2'd3:    q = dat[24 +: W];
            default: q = dat[W-1:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dat       <= '0;
            shamt     <= '0;
            state     <= IDLE;
            sh_done   <= 1'b0;
            sh_done_r <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dat       <= dat_next;
            sh_done_r <= sh_done;
            case (state)
                IDLE: begin
                    if (bus.i_en & bus.i_init & bus.i_shift_op) begin
                        state <= INIT;
                    end
                end
                INIT: begin
                    // An instruction abort takes precedence over the exit beat.
                    if (!bus.i_shift_op) begin
                        state <= IDLE;
                    end else if (bus.i_en & bus.i_cnt_done) begin
                        shamt <= {1'b0, dat_next[4:0]};
                        if (dat_next[4:0] != 5'd0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state   <= DONE;
                            sh_done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shamt != 6'd0) begin
                        shamt <= shamt - 6'd1;
                    end
                    if (shamt == 6'd1) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        sh_done <= 1'b1;
                    end
                end
                DONE: begin
                    if ((bus.i_en & bus.i_cnt_done & ~bus.i_init) | ~bus.i_shift_op) begin
                        state   <= IDLE;
                        sh_done <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    sh_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_op_b      = op_b;
    assign bus.o_dat       = dat;
    assign bus.o_q         = q;
    assign bus.o_sh_done   = sh_done;
    assign bus.o_sh_done_r = sh_done_r;
    assign bus.o_busy      = busy;
endmodule

// File: tb/tb_serv_bufreg2_w.sv
// Bench for serv_bufreg2_w: W=1, 4 and 8 instances share one stimulus stream and are
// compared every cycle against a timestamp-based behavioural model.
module tb_serv_bufreg2_w;
    typedef struct packed {
        logic        en;
        logic        init;
        logic        cnt_done;
        logic        shift_op;
        logic        byte_valid;
        logic        load;
        logic        sel;
        logic [7:0]  rs2;
        logic [7:0]  imm;
        logic [1:0]  lsb;
        logic [31:0] rdat;
    } stim_t;

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_SHIFT = 2;
    localparam int P_DONE  = 3;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    stim_t s = '0;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    serv_bufreg2_w_if #(.W(1)) bus1 ();
    serv_bufreg2_w_if #(.W(4)) bus4 ();
    serv_bufreg2_w_if #(.W(8)) bus8 ();

    assign bus1.i_en = s.en;         assign bus4.i_en = s.en;         assign bus8.i_en = s.en;
    assign bus1.i_init = s.init;     assign bus4.i_init = s.init;     assign bus8.i_init = s.init;
    assign bus1.i_cnt_done = s.cnt_done;
    assign bus4.i_cnt_done = s.cnt_done;
    assign bus8.i_cnt_done = s.cnt_done;
    assign bus1.i_shift_op = s.shift_op;
    assign bus4.i_shift_op = s.shift_op;
    assign bus8.i_shift_op = s.shift_op;
    assign bus1.i_byte_valid = s.byte_valid;
    assign bus4.i_byte_valid = s.byte_valid;
    assign bus8.i_byte_valid = s.byte_valid;
    assign bus1.i_load = s.load;     assign bus4.i_load = s.load;     assign bus8.i_load = s.load;
    assign bus1.i_dat = s.rdat;      assign bus4.i_dat = s.rdat;      assign bus8.i_dat = s.rdat;
    assign bus1.i_op_b_sel = s.sel;  assign bus4.i_op_b_sel = s.sel;  assign bus8.i_op_b_sel = s.sel;
    assign bus1.i_rs2 = s.rs2[0:0];  assign bus4.i_rs2 = s.rs2[3:0];  assign bus8.i_rs2 = s.rs2;
    assign bus1.i_imm = s.imm[0:0];  assign bus4.i_imm = s.imm[3:0];  assign bus8.i_imm = s.imm;
    assign bus1.i_lsb = s.lsb;       assign bus4.i_lsb = s.lsb;       assign bus8.i_lsb = s.lsb;

    serv_bufreg2_w #(.W(1), .XLEN(32)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));
    serv_bufreg2_w #(.W(4), .XLEN(32)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4.slave));
    serv_bufreg2_w #(.W(8), .XLEN(32)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8.slave));

    // Behavioural model: data word per width, phase, and the edge at which a shift began.
    logic [31:0] m_dat [3];
    int          m_phase [3];
    int          m_exit [3];
    int          m_amt [3];
    logic        m_done_r [3];
    logic        m_valid = 1'b0;
    int          cyc = 0;

    function automatic int widthOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    function automatic logic [7:0] maskOf(input int w);
        logic [8:0] m;
        m = (9'd1 << w) - 9'd1;
        return m[7:0];
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] nd;
        logic [7:0]  ob;
        logic        fill;
        int          w;
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            w = widthOf(k);
            if (!rst_n) begin
                m_dat[k]    = 32'h0;
                m_phase[k]  = P_IDLE;
                m_done_r[k] = 1'b0;
            end else begin
                ob   = maskOf(w) & (s.sel ? s.rs2 : s.imm);
                fill = s.en && (m_phase[k] == P_IDLE || m_phase[k] == P_INIT) &&
                       (s.byte_valid || (s.shift_op && m_phase[k] == P_INIT));
                nd = m_dat[k];
                if (s.load) nd = s.rdat;
                else if (fill) nd = (m_dat[k] >> w) | ({24'h0, ob} << (32 - w));
                m_done_r[k] = (m_phase[k] == P_DONE);
                case (m_phase[k])
                    P_IDLE: if (s.en && s.init && s.shift_op) m_phase[k] = P_INIT;
                    P_INIT: begin
                        if (!s.shift_op) m_phase[k] = P_IDLE;
                        else if (s.en && s.cnt_done) begin
                            m_amt[k]   = int'(nd % 32);
                            m_exit[k]  = cyc;
                            m_phase[k] = (m_amt[k] == 0) ? P_DONE : P_SHIFT;
                        end
                    end
                    P_SHIFT: if (cyc - m_exit[k] == m_amt[k]) m_phase[k] = P_DONE;
                    default: if ((s.en && s.cnt_done && !s.init) || !s.shift_op) m_phase[k] = P_IDLE;
                endcase
                m_dat[k] = nd;
            end
        end
        m_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareInst(input string tag, input int k, input logic [7:0] op_b,
                               input logic [31:0] dat, input logic [7:0] q,
                               input logic done, input logic done_r, input logic busy);
        logic [7:0] mk;
        mk = maskOf(widthOf(k));
        checkOutput({tag, ".o_op_b"}, {24'h0, op_b}, {24'h0, mk & (s.sel ? s.rs2 : s.imm)});
        checkOutput({tag, ".o_dat"}, dat, m_dat[k]);
        checkOutput({tag, ".o_q"}, {24'h0, q}, {24'h0, mk & 8'(m_dat[k] >> (8 * s.lsb))});
        checkOutput({tag, ".o_sh_done"}, {31'h0, done}, {31'h0, m_phase[k] == P_DONE});
        checkOutput({tag, ".o_sh_done_r"}, {31'h0, done_r}, {31'h0, m_done_r[k]});
        checkOutput({tag, ".o_busy"}, {31'h0, busy}, {31'h0, m_phase[k] == P_SHIFT});
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            compareInst("w1", 0, {7'h0, bus1.o_op_b}, bus1.o_dat, {7'h0, bus1.o_q},
                        bus1.o_sh_done, bus1.o_sh_done_r, bus1.o_busy);
            compareInst("w4", 1, {4'h0, bus4.o_op_b}, bus4.o_dat, {4'h0, bus4.o_q},
                        bus4.o_sh_done, bus4.o_sh_done_r, bus4.o_busy);
            compareInst("w8", 2, bus8.o_op_b, bus8.o_dat, bus8.o_q,
                        bus8.o_sh_done, bus8.o_sh_done_r, bus8.o_busy);
        end
    end

    task automatic applyStimulus(input stim_t n);
        s = n;
        @(posedge clk);
        #2;
    endtask

    function automatic stim_t randStim();
        stim_t t;
        t.en         = ($urandom_range(0, 9) < 7);
        t.init       = ($urandom_range(0, 9) < 3);
        t.cnt_done   = ($urandom_range(0, 9) == 0);
        t.shift_op   = ($urandom_range(0, 9) != 0);
        t.byte_valid = $urandom_range(0, 1) == 1;
        t.load       = ($urandom_range(0, 19) == 0);
        t.sel        = $urandom_range(0, 1) == 1;
        t.rs2        = 8'($urandom);
        t.imm        = 8'($urandom);
        t.lsb        = 2'($urandom);
        t.rdat       = $urandom;
        return t;
    endfunction

    // Shifts a word in LSB-first on the W=1 lane during an init phase ending on cnt_done.
    task automatic sendShiftWord(input logic [31:0] word);
        stim_t t;
        for (int i = 0; i < 32; i++) begin
            t            = '0;
            t.en         = 1'b1;
            t.init       = 1'b1;
            t.shift_op   = 1'b1;
            t.byte_valid = 1'b1;
            t.sel        = 1'b1;
            t.rs2        = 8'($urandom);
            t.rs2[0]     = word[i];
            t.cnt_done   = (i == 31);
            applyStimulus(t);
        end
        t          = '0;
        t.shift_op = 1'b1;
        s          = t;
    endtask

    task automatic measureShift(output int busy_cnt, output int done_at, output int done_r_at);
        stim_t t;
        busy_cnt  = 0;
        done_at   = -1;
        done_r_at = -1;
        for (int j = 0; j < 25; j++) begin
            if (bus1.o_busy) busy_cnt++;
            if (bus1.o_sh_done && done_at < 0) done_at = j;
            if (bus1.o_sh_done_r && done_r_at < 0) done_r_at = j;
            applyStimulus(s);
        end
        t = '0;
        applyStimulus(t);
    endtask

    initial begin
        stim_t t;
        int    busy_cnt, done_at, done_r_at, seen;

        rst_n = 1'b0;
        applyStimulus(randStim());
        applyStimulus(randStim());
        checkOutput("reset o_dat w4", bus4.o_dat, 32'h0);
        checkOutput("reset o_dat w1", bus1.o_dat, 32'h0);
        checkOutput("reset o_sh_done", {31'h0, bus8.o_sh_done}, 32'h0);
        checkOutput("reset o_sh_done_r", {31'h0, bus8.o_sh_done_r}, 32'h0);
        checkOutput("reset o_busy", {31'h0, bus1.o_busy}, 32'h0);
        rst_n = 1'b1;

        t = '0;
        t.en = 1'b1; t.byte_valid = 1'b1; t.sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t.rs2 = 8'(8 - i);
            applyStimulus(t);
        end
        checkOutput("fill w4", bus4.o_dat, 32'h12345678);

        for (int i = 0; i < 8; i++) begin
            t.rs2 = 8'(8 - i);
            t.byte_valid = (i >= 2);
            applyStimulus(t);
            if (i == 1) checkOutput("fill hold w4", bus4.o_dat, 32'h12345678);
        end
        checkOutput("fill masked w4", bus4.o_dat, 32'h12345612);
        applyStimulus('0);

        sendShiftWord(32'h5);
        measureShift(busy_cnt, done_at, done_r_at);
        checkOutput("shift5 busy cycles", busy_cnt, 5);
        checkOutput("shift5 sh_done at", done_at, 5);
        checkOutput("shift5 sh_done_r at", done_r_at, 6);

        sendShiftWord(32'hA0);
        measureShift(busy_cnt, done_at, done_r_at);
        checkOutput("shift0 busy cycles", busy_cnt, 0);
        checkOutput("shift0 sh_done at", done_at, 0);
        checkOutput("shift0 sh_done_r at", done_r_at, 1);

        t = '0; t.load = 1'b1; t.rdat = 32'hAABBCCDD;
        applyStimulus(t);
        for (int l = 0; l < 4; l++) begin
            t = '0; t.lsb = 2'(l);
            s = t;
            #1;
            checkOutput($sformatf("lane w8 lsb%0d", l), {24'h0, bus8.o_q},
                        32'hAABBCCDD >> (8 * l) & 32'hFF);
        end
        applyStimulus(s);

        t = '0; t.load = 1'b1; t.en = 1'b1; t.byte_valid = 1'b1; t.sel = 1'b1;
        t.rs2 = 8'hFF; t.rdat = 32'h5A5AC3C3;
        applyStimulus(t);
        checkOutput("collision w1", bus1.o_dat, 32'h5A5AC3C3);
        checkOutput("collision w4", bus4.o_dat, 32'h5A5AC3C3);
        checkOutput("collision w8", bus8.o_dat, 32'h5A5AC3C3);
        applyStimulus('0);

        sendShiftWord(32'd20);
        applyStimulus(s);
        applyStimulus(s);
        rst_n = 1'b0;
        applyStimulus(s);
        rst_n = 1'b1;
        checkOutput("abort rst busy", {31'h0, bus1.o_busy}, 32'h0);
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            if (bus1.o_sh_done || bus1.o_busy) seen++;
            applyStimulus(s);
        end
        checkOutput("abort rst no done", seen, 0);

        t = '0; t.en = 1'b1; t.init = 1'b1; t.shift_op = 1'b1; t.byte_valid = 1'b1;
        t.sel = 1'b1; t.rs2 = 8'hFF;
        for (int i = 0; i < 10; i++) applyStimulus(t);
        t.shift_op = 1'b0;
        applyStimulus(t);
        t.shift_op = 1'b1; t.init = 1'b0; t.cnt_done = 1'b1;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            applyStimulus(t);
            if (bus1.o_sh_done || bus1.o_busy) seen++;
        end
        checkOutput("abort init idle", seen, 0);
        applyStimulus('0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(randStim());
        end
        rst_n = 1'b1;
        applyStimulus('0);
        applyStimulus('0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
